// File: rtl/pulse_capture_pkg.sv
// Shared types and constants for the pulse capture block.
package pulse_capture_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } capState_t;

  localparam logic POL_RISE = 1'b1;
  localparam logic POL_FALL = 1'b0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pulse_capture_if.sv
// Event word stream: {polarity, timestamp} with valid/ready handshake.
interface pulse_capture_if #(
  parameter int CNT_W = 16
) ();
  logic [CNT_W:0] oDATA;
  logic           oVALID;
  logic           iREADY;

  modport master (output oDATA, output oVALID, input iREADY);
  modport slave  (input oDATA, input oVALID, output iREADY);
endinterface

// File: rtl/pulse_capture_fifo.sv
// Synchronous event FIFO; head word is held in a register so it stays stable
// while the consumer stalls. A full FIFO still accepts a push if it pops.
module pulse_capture_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         iCLK,
  input  logic         iRESETn,
  input  logic         wrEn,
  input  logic [W-1:0] wrData,
  input  logic         rdEn,
  output logic [W-1:0] rdData,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr, nextRd;
  logic [AW:0]   count, countNext;
  logic          doPush, doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = rdEn & ~empty;
  assign doPush = wrEn & (~full | doPop);
  assign nextRd = rdPtr + 1'b1;

  always_comb begin
    countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);
  end

  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      rdData <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= nextRd;
      count <= countNext;
      // Refresh the head register whenever the head entry changes.
      if (doPop) begin
        if (count > (AW+1)'(1)) rdData <= mem[nextRd];
        else if (doPush)        rdData <= wrData;
      end else if (empty && doPush) begin
        rdData <= wrData;
      end
    end
  end
endmodule

// File: rtl/pulse_capture.sv
// Timestamps iRF edges inside a WINDOW-cycle capture window opened by an iTRIG
// rising edge. Define PULSE_CAPTURE_GLITCH_FILTER_EN to add a 3-sample majority
// filter on iRF (rejects pulses shorter than 2 cycles, adds 2 cycles latency).
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1000,
  parameter int DEPTH  = 8
) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iTRIG,
  input  logic iRF,
  output logic oBUSY,
  output logic oOVERFLOW,
  pulse_capture_if.master evt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  capState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       trigSync;
  logic             trigRise, rfRise, rfFall;
  logic             push, drop, fifoFull, fifoEmpty;
  logic [CNT_W:0]   fifoData;

  // [1:0] synchroniser, [2] previous sample for edge detection
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      trigSync <= '0;
      trigRise <= 1'b0;
    end else begin
      trigSync <= {trigSync[1:0], iTRIG};
      trigRise <= trigSync[1] & ~trigSync[2];
    end
  end

`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  logic [3:0] rfSync;
  logic       rfMaj, rfMajD;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rfSync <= '0;
      rfMaj  <= 1'b0;
      rfMajD <= 1'b0;
      rfRise <= 1'b0;
      rfFall <= 1'b0;
    end else begin
      rfSync <= {rfSync[2:0], iRF};
      rfMaj  <= maj3(rfSync[1], rfSync[2], rfSync[3]);
      rfMajD <= rfMaj;
      rfRise <= rfMaj & ~rfMajD;
      rfFall <= ~rfMaj & rfMajD;
    end
  end
`else
  logic [2:0] rfSync;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rfSync <= '0;
      rfRise <= 1'b0;
      rfFall <= 1'b0;
    end else begin
      rfSync <= {rfSync[1:0], iRF};
      rfRise <= rfSync[1] & ~rfSync[2];
      rfFall <= ~rfSync[1] & rfSync[2];
    end
  end
`endif

  // Edges in the IDLE->CAPTURE cycle are dropped because state is still IDLE.
  assign push = (state == CAPTURE) & (rfRise | rfFall);
  assign drop = push & fifoFull & ~evt.iREADY;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      oBUSY     <= 1'b0;
      oOVERFLOW <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigRise) begin
            state     <= CAPTURE;
            cnt       <= '0;
            oBUSY     <= 1'b1;
            oOVERFLOW <= 1'b0;
          end
        end
        CAPTURE: begin
          if (drop) oOVERFLOW <= 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pulse_capture_fifo #(
    .W     (CNT_W + 1),
    .DEPTH (DEPTH)
  ) uFifo (
    .iCLK    (iCLK),
    .iRESETn (iRESETn),
    .wrEn    (push),
    .wrData  ({rfRise ? POL_RISE : POL_FALL, cnt}),
    .rdEn    (evt.iREADY),
    .rdData  (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign evt.oDATA  = fifoData;
  assign evt.oVALID = ~fifoEmpty;
endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture (default parameters). Stimulus is placed
// relative to the window counter `cur`, which is 0 in the first busy cycle.
module tb_pulse_capture;
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int RF_LAT = 5;
  localparam int GLITCH_WORDS = 0;
`else
  localparam int RF_LAT = 3;
  localparam int GLITCH_WORDS = 2;
`endif

  logic iCLK = 1'b0, iRESETn = 1'b0, iTRIG = 1'b0, iRF = 1'b0;
  logic oBUSY, oOVERFLOW;
  int   comps = 0, errs = 0, cur = 0, busyCnt = 0;
  logic [16:0] got[$];

  pulse_capture_if #(.CNT_W(16)) evt ();

  pulse_capture #(.CNT_W(16), .WINDOW(1000), .DEPTH(8)) dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iTRIG(iTRIG), .iRF(iRF),
    .oBUSY(oBUSY), .oOVERFLOW(oOVERFLOW), .evt(evt)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (evt.oVALID && evt.iREADY) got.push_back(evt.oDATA);
    if (oBUSY) busyCnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  task automatic step_to(input int target);
    while (cur < target) begin tick(1); cur++; end
  endtask

  // Trigger pin rises now; detection 3 cycles later, counter 0 one cycle after.
  task automatic start_trig();
    busyCnt = 0;
    got.delete();
    iTRIG = 1'b1;
    tick(4);
    cur = 0;
    iTRIG = 1'b0;
  endtask

  task automatic test_reset();
    iRESETn = 1'b0; iTRIG = 1'b0; iRF = 1'b0; evt.iREADY = 1'b0;
    tick(3);
    comps++; if (evt.oVALID !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", evt.oVALID); end
    comps++; if (oBUSY !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", oBUSY); end
    comps++; if (oOVERFLOW !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b exp 0", oOVERFLOW); end
    comps++; if (evt.oDATA !== 17'h0) begin errs++; $display("FAIL reset_data got %h exp 0", evt.oDATA); end
    iRESETn = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    evt.iREADY = 1'b1;
    start_trig();
    comps++; if (oBUSY !== 1'b1) begin errs++; $display("FAIL basic_busy_start got %b exp 1", oBUSY); end
    step_to(10 - RF_LAT); iRF = 1'b1;
    step_to(10);
    comps++; if (evt.oVALID !== 1'b0) begin errs++; $display("FAIL basic_lat0 got %b exp 0", evt.oVALID); end
    step_to(11);
    comps++; if (evt.oVALID !== 1'b1) begin errs++; $display("FAIL basic_lat1 got %b exp 1", evt.oVALID); end
    comps++; if (evt.oDATA !== {1'b1, 16'd10}) begin errs++; $display("FAIL basic_head got %h exp %h", evt.oDATA, {1'b1, 16'd10}); end
    step_to(15 - RF_LAT); iRF = 1'b0;
    step_to(999);
    comps++; if (oBUSY !== 1'b1) begin errs++; $display("FAIL basic_busy_999 got %b exp 1", oBUSY); end
    step_to(1000);
    comps++; if (oBUSY !== 1'b0) begin errs++; $display("FAIL basic_busy_1000 got %b exp 0", oBUSY); end
    comps++; if (busyCnt !== 1000) begin errs++; $display("FAIL basic_busy_len got %0d exp 1000", busyCnt); end
    comps++; if (got.size() !== 2) begin errs++; $display("FAIL basic_words got %0d exp 2", got.size()); end
    comps++; if (got.size() < 1 || got[0] !== {1'b1, 16'd10}) begin errs++; $display("FAIL basic_w0 got %h exp %h", (got.size() > 0) ? got[0] : 17'h0, {1'b1, 16'd10}); end
    comps++; if (got.size() < 2 || got[1] !== {1'b0, 16'd15}) begin errs++; $display("FAIL basic_w1 got %h exp %h", (got.size() > 1) ? got[1] : 17'h0, {1'b0, 16'd15}); end
    tick(5);
  endtask

  // Nine edges at counters 20,22,...,36 with the consumer stalled.
  task automatic test_overflow();
    logic [16:0] exp;
    evt.iREADY = 1'b0;
    start_trig();
    for (int i = 0; i < 9; i++) begin
      step_to(20 + 2 * i - RF_LAT);
      iRF = (i % 2 == 0);
    end
    step_to(40);
    comps++; if (oOVERFLOW !== 1'b1) begin errs++; $display("FAIL ovf_set got %b exp 1", oOVERFLOW); end
    comps++; if (evt.oDATA !== {1'b1, 16'd20}) begin errs++; $display("FAIL ovf_head got %h exp %h", evt.oDATA, {1'b1, 16'd20}); end
    step_to(45);
    comps++; if (evt.oVALID !== 1'b1 || evt.oDATA !== {1'b1, 16'd20}) begin errs++; $display("FAIL ovf_hold got %b/%h exp 1/%h", evt.oVALID, evt.oDATA, {1'b1, 16'd20}); end
    step_to(1000);
    iRF = 1'b0;
    comps++; if (oOVERFLOW !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", oOVERFLOW); end
    evt.iREADY = 1'b1;
    tick(12);
    evt.iREADY = 1'b0;
    comps++; if (got.size() !== 8) begin errs++; $display("FAIL ovf_words got %0d exp 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {(i % 2 == 0), 16'(20 + 2 * i)};
      comps++; if (i >= got.size() || got[i] !== exp) begin errs++; $display("FAIL ovf_w%0d got %h exp %h", i, (i < got.size()) ? got[i] : 17'h0, exp); end
    end
    comps++; if (oOVERFLOW !== 1'b1) begin errs++; $display("FAIL ovf_after_drain got %b exp 1", oOVERFLOW); end
  endtask

  // Eight edges fill the FIFO; a ninth arrives in the one cycle iREADY is high.
  task automatic test_full_pop();
    evt.iREADY = 1'b0;
    start_trig();
    comps++; if (oOVERFLOW !== 1'b0) begin errs++; $display("FAIL fp_ovf_clear got %b exp 0", oOVERFLOW); end
    for (int i = 0; i < 8; i++) begin
      step_to(20 + 2 * i - RF_LAT);
      iRF = (i % 2 == 0);
    end
    step_to(40 - RF_LAT); iRF = 1'b1;
    step_to(40); evt.iREADY = 1'b1;
    step_to(41); evt.iREADY = 1'b0;
    comps++; if (oOVERFLOW !== 1'b0) begin errs++; $display("FAIL fp_no_ovf got %b exp 0", oOVERFLOW); end
    comps++; if (evt.oDATA !== {1'b0, 16'd22}) begin errs++; $display("FAIL fp_head got %h exp %h", evt.oDATA, {1'b0, 16'd22}); end
    comps++; if (got.size() !== 1) begin errs++; $display("FAIL fp_one_pop got %0d exp 1", got.size()); end
    evt.iREADY = 1'b1;
    step_to(60);
    evt.iREADY = 1'b0;
    comps++; if (got.size() !== 9) begin errs++; $display("FAIL fp_words got %0d exp 9", got.size()); end
    comps++; if (got.size() < 9 || got[8] !== {1'b1, 16'd40}) begin errs++; $display("FAIL fp_last got %h exp %h", (got.size() > 8) ? got[8] : 17'h0, {1'b1, 16'd40}); end
    step_to(1000);
    iRF = 1'b0;
    tick(5);
  endtask

  task automatic test_retrigger();
    start_trig();
    step_to(400 - 3); iTRIG = 1'b1;
    step_to(405);     iTRIG = 1'b0;
    step_to(999);
    comps++; if (oBUSY !== 1'b1) begin errs++; $display("FAIL rt_busy_999 got %b exp 1", oBUSY); end
    step_to(1000);
    comps++; if (oBUSY !== 1'b0) begin errs++; $display("FAIL rt_busy_1000 got %b exp 0", oBUSY); end
    comps++; if (busyCnt !== 1000) begin errs++; $display("FAIL rt_busy_len got %0d exp 1000", busyCnt); end
    tick(5);
  endtask

  task automatic test_reset_mid();
    evt.iREADY = 1'b0;
    start_trig();
    for (int i = 0; i < 3; i++) begin
      step_to(10 + 2 * i - RF_LAT);
      iRF = (i % 2 == 0);
    end
    step_to(500);
    comps++; if (evt.oVALID !== 1'b1) begin errs++; $display("FAIL rm_pre_valid got %b exp 1", evt.oVALID); end
    iRESETn = 1'b0;
    #1;
    comps++; if (evt.oVALID !== 1'b0) begin errs++; $display("FAIL rm_valid got %b exp 0", evt.oVALID); end
    comps++; if (oBUSY !== 1'b0) begin errs++; $display("FAIL rm_busy got %b exp 0", oBUSY); end
    comps++; if (evt.oDATA !== 17'h0) begin errs++; $display("FAIL rm_data got %h exp 0", evt.oDATA); end
    tick(2);
    got.delete();
    iRESETn = 1'b1;
    evt.iREADY = 1'b1;
    tick(5); iRF = 1'b0;
    tick(5); iRF = 1'b1;
    tick(5); iRF = 1'b0;
    tick(10);
    comps++; if (got.size() !== 0) begin errs++; $display("FAIL rm_words got %0d exp 0", got.size()); end
    comps++; if (oBUSY !== 1'b0) begin errs++; $display("FAIL rm_busy_after got %b exp 0", oBUSY); end
  endtask

  task automatic test_glitch();
    evt.iREADY = 1'b1;
    start_trig();
    step_to(50); iRF = 1'b1;
    step_to(51); iRF = 1'b0;
    step_to(70);
    comps++; if (got.size() !== GLITCH_WORDS) begin errs++; $display("FAIL gl_words got %0d exp %0d", got.size(), GLITCH_WORDS); end
`ifndef PULSE_CAPTURE_GLITCH_FILTER_EN
    comps++; if (got.size() < 2 || got[0] !== {1'b1, 16'd53} || got[1] !== {1'b0, 16'd54}) begin
      errs++; $display("FAIL gl_data got %h/%h exp %h/%h", (got.size() > 0) ? got[0] : 17'h0, (got.size() > 1) ? got[1] : 17'h0, {1'b1, 16'd53}, {1'b0, 16'd54});
    end
`endif
    step_to(1001);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_retrigger();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end
endmodule

// File: doc/pulse_capture.md
PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, timestamp counter width in bits.
REQ-002 SHALL have parameter WINDOW, default 1000, capture window length in clock cycles (2..2^CNT_W).
REQ-003 SHALL have parameter DEPTH, default 8, event FIFO depth (power of two, >=2).
REQ-004 SHALL have port iCLK, input, 1, single clock (80 MHz internal oscillator domain).
REQ-005 SHALL have port iRESETn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iTRIG, input, 1, asynchronous trigger pin; a rising edge starts capture.
REQ-007 SHALL have port iRF, input, 1, asynchronous monitored pulse line (returned RF pulse sequence).
REQ-008 SHALL have port oDATA, output, CNT_W+1, event word {polarity, timestamp}; polarity 1 = rising, 0 = falling.
REQ-009 SHALL have port oVALID, output, 1, oDATA holds a valid event.
REQ-010 SHALL have port iREADY, input, 1, consumer accepts oDATA.
REQ-011 SHALL have port oBUSY, output, 1, capture window open.
REQ-012 SHALL have port oOVERFLOW, output, 1, sticky flag: an event was dropped.

Function
REQ-013 SHALL pass iTRIG and iRF through 2-flop synchronisers, then a registered edge detector; edge detection = 3 cycles after the pin transition.
REQ-014 SHALL implement FSM IDLE -> CAPTURE on a detected iTRIG rising edge; CAPTURE -> IDLE when the counter equals WINDOW-1.
REQ-015 SHALL ignore iTRIG edges while in CAPTURE (no restart, no counter reset).
REQ-016 SHALL clear the counter to 0 on the IDLE->CAPTURE transition and increment it by 1 each CAPTURE cycle; the counter never wraps within a window.
REQ-017 SHALL, in CAPTURE, push {polarity, counter} on each detected iRF edge; the timestamp is the counter value in the detection cycle.
REQ-018 SHALL ignore iRF edges in IDLE, including the cycle of the IDLE->CAPTURE transition.
REQ-019 SHALL drive oBUSY high exactly while in CAPTURE.
REQ-020 SHALL use a valid/ready handshake: one word is transferred when oVALID && iREADY on a rising iCLK edge.
REQ-021 SHALL hold oDATA stable while oVALID=1 and iREADY=0.
REQ-022 SHALL assert oVALID the cycle after a push into an empty FIFO (first-word latency 1).
REQ-023 SHALL drop a push when the FIFO is full and no pop occurs in that cycle, and set oOVERFLOW.
REQ-024 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle; occupancy is unchanged.
REQ-025 SHALL keep occupancy unchanged on a simultaneous push and pop at any non-empty level.
REQ-026 SHALL clear oOVERFLOW only on the next IDLE->CAPTURE transition, or on reset.
REQ-027 SHALL leave unread FIFO contents intact across window end and new triggers.

Reset
REQ-028 SHALL, on iRESETn low, asynchronously set: state IDLE, counter 0, FIFO empty, oVALID 0, oBUSY 0, oOVERFLOW 0, oDATA 0, synchroniser flops 0.
REQ-029 SHALL, on reset mid-capture, discard all buffered events and the partial window; no event is emitted after reset release until a new trigger.

Configuration
REQ-030 SHALL, with macro PULSE_CAPTURE_GLITCH_FILTER_EN defined, insert a 3-sample majority filter on synchronised iRF before edge detection; pulses shorter than 2 cycles are rejected and edge detection latency becomes 5 cycles.
REQ-031 SHALL, without PULSE_CAPTURE_GLITCH_FILTER_EN, omit the filter; iRF edge latency is 3 cycles and 1-cycle pulses are captured.

Structure
REQ-032 SHALL place the FSM state type (IDLE, CAPTURE) and the polarity bit constants in package pulse_capture_pkg.
REQ-033 SHALL implement the event buffer as sub-module pulse_capture_fifo (synchronous, parameterised width/depth, full/empty, registered output).

Verification
REQ-034 SHALL cover: trigger edge at T, iRF high at T+10 for 5 cycles -> words {1,10} then {0,15}; oBUSY high for 1000 cycles.
REQ-035 SHALL cover: iREADY=0 while 9 edges arrive (DEPTH=8) -> 8 words buffered, 9th dropped, oOVERFLOW=1 until the next trigger.
REQ-036 SHALL cover: FIFO full, iREADY=1 in the same cycle as a new edge -> edge accepted, no overflow.
REQ-037 SHALL cover: second iTRIG edge at counter 400 -> ignored; window still closes at counter 999.
REQ-038 SHALL cover: iRESETn low at counter 500 with 3 buffered words -> oVALID=0 immediately; no words after release until a new trigger.
REQ-039 SHALL cover: 1-cycle iRF pulse -> 2 words without PULSE_CAPTURE_GLITCH_FILTER_EN, 0 words with it.
